stage_if: RTL and testbench

Instruction-fetch stage directly upstream of decode. It issues sequential word fetches to the instruction memory/I$ port and buffers in-order responses in a small FIFO. Each cycle it presents at most one instruction to decode on i_valid/i_instr/i_pc/i_npc. On a restart from decode or later stages it redirects, discards in-flight and buffered instructions, and resumes at the restart PC.

---
 rtl/stage_if_pkg.sv | 17 +
 rtl/stage_if_if.sv | 28 ++
 rtl/stage_if_fetch_fifo.sv | 64 ++++++
 rtl/stage_if.sv | 138 +++++++++++++
 tb/tb_stage_if.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package stage_if_pkg;

    localparam logic [31:0]  BOOT_PC_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned  INSTR_W         = 32;

    // One buffered fetch: the instruction word tagged with its own address.
    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Instruction memory / I$ port: request channel plus in-order response channel.
interface stage_if_if;

    logic                               req_valid;
    logic                               req_ready;
    logic [31:0]                        req_addr;
    logic                               rsp_valid;
    logic [stage_if_pkg::INSTR_W-1:0]   rsp_data;

    // Fetch stage side.
    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // Memory side.
    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/stage_if_fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between memory responses and decode.
module stage_if_fetch_fifo
    import stage_if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop & ~empty;
    assign rdata  = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Entry storage needs no reset: only occupied slots are ever read.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: sequential fetch with credit flow control, in-order
// response buffering, and restart handling that discards stale responses.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] BOOT_PC = BOOT_PC_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter bit          debug   = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               restart,
    input  logic [31:0]        restart_pc,
    stage_if_if.master         imem,
    output logic               i_valid,
    output logic [INSTR_W-1:0] i_instr,
    output logic [31:0]        i_pc,
    output logic [31:0]        i_npc,
    output logic [31:0]        perf_restart_discards
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        rsp_pc_q, rsp_pc_d;
    logic [CntW-1:0]    inflight_q, inflight_d;
    logic [CntW-1:0]    drop_q, drop_d;
    logic               i_valid_q;
    logic [INSTR_W-1:0] i_instr_q;
    logic [31:0]        i_pc_q;
    logic [31:0]        i_npc_q;
    logic [31:0]        perf_q;

    logic [CntW:0]      credit_used;
    logic               accept;
    logic               drop_rsp;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [CntW-1:0]    fifo_count;
    fetch_entry_t       fifo_head;

    // A request may only go out if a FIFO slot is guaranteed for its response.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign imem.req_valid = ~reset & ~restart & (credit_used < (CntW+1)'(DEPTH));
    assign imem.req_addr  = word_align(fetch_pc_q);
    assign accept         = imem.req_valid & imem.req_ready;

    // Responses to pre-restart requests are discarded, including one landing on the restart cycle.
    assign drop_rsp  = imem.rsp_valid & (restart | (drop_q != '0));
    assign fifo_push = imem.rsp_valid & ~drop_rsp;
    assign fifo_pop  = ~restart & ~fifo_empty;

    stage_if_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (restart),
        .wdata ('{pc: rsp_pc_q, instr: imem.rsp_data}),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state for fetch PC, response PC, credit and discard counters.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CntW'(accept) - CntW'(imem.rsp_valid);
        if (restart) begin
            fetch_pc_d = word_align(restart_pc);
            rsp_pc_d   = word_align(restart_pc);
            // Everything still outstanding belongs to the old stream.
            drop_d     = inflight_d;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (fifo_push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
            if (drop_rsp) begin
                drop_d = drop_q - CntW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= BOOT_PC;
            rsp_pc_q   <= BOOT_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Decode-facing registers: pop the head unless redirecting, otherwise hold the last values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_valid_q <= 1'b0;
            i_instr_q <= '0;
            i_pc_q    <= '0;
            i_npc_q   <= '0;
            perf_q    <= '0;
        end else begin
            i_valid_q <= fifo_pop;
            if (fifo_pop) begin
                i_instr_q <= fifo_head.instr;
                i_pc_q    <= fifo_head.pc;
                i_npc_q   <= fifo_head.pc + 32'd4;
            end
            if (drop_rsp) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    assign i_valid               = i_valid_q;
    assign i_instr               = i_instr_q;
    assign i_pc                  = i_pc_q;
    assign i_npc                 = i_npc_q;
    assign perf_restart_discards = perf_q;

    // The credit rule makes overflow impossible; this only guards against a broken credit path.
    assert property (@(posedge clock) disable iff (reset)
        !(debug && fifo_push && !fifo_pop && (fifo_count == CntW'(DEPTH))));

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: randomised memory with a stream-level reference model.
module tb_stage_if;
    import stage_if_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'hBFC0_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic [31:0] restart_pc = '0;
    logic        i_valid;
    logic [31:0] i_instr, i_pc, i_npc, perf;

    stage_if_if imem ();

    stage_if #(
        .BOOT_PC (BOOT),
        .DEPTH   (DEPTH),
        .debug   (1'b1)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .restart               (restart),
        .restart_pc            (restart_pc),
        .imem                  (imem),
        .i_valid               (i_valid),
        .i_instr               (i_instr),
        .i_pc                  (i_pc),
        .i_npc                 (i_npc),
        .perf_restart_discards (perf)
    );

    always #5 clock = ~clock;

    // Memory / reference model state.
    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } pend_t;

    pend_t       mem_q[$];     // requests accepted by memory, in order
    logic [31:0] m_out[$];     // kept responses not yet delivered to decode
    int unsigned e, last_due, m_epoch;
    int unsigned lat_min = 1, lat_max = 1, ready_pct = 100;
    logic [31:0] m_fetch_pc, m_perf;
    logic        exp_i_valid, exp_req_valid, obs_req_valid;
    logic [31:0] exp_i_pc, exp_i_instr, exp_i_npc, exp_req_addr, obs_req_addr;
    int          n_cmp = 0, n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_0000;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        restart = 1'b0;
        imem.req_ready = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.rsp_data = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        mem_q.delete();
        m_out.delete();
        e = 0; last_due = 0; m_epoch = 0;
        m_fetch_pc = BOOT; m_perf = 0;
        exp_i_valid = 0; exp_i_pc = 0; exp_i_instr = 0; exp_i_npc = 0;
    endtask

    // One clock: drive memory, capture the request, then advance the stream model.
    task automatic step();
        pend_t       h;
        logic        rsp, pop;
        int unsigned lat, due;
        imem.req_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
        rsp = (mem_q.size() > 0) && (mem_q[0].due == e + 1);
        imem.rsp_valid = rsp;
        imem.rsp_data = rsp ? mem_word(mem_q[0].addr) : $urandom;
        #1;
        exp_req_valid = !restart && (mem_q.size() + m_out.size() < DEPTH);
        exp_req_addr  = m_fetch_pc;
        obs_req_valid = imem.req_valid;
        obs_req_addr  = imem.req_addr;
        @(posedge clock);
        e++;
        pop = !restart && (m_out.size() > 0);
        exp_i_valid = pop;
        if (pop) begin
            exp_i_pc    = m_out.pop_front();
            exp_i_instr = mem_word(exp_i_pc);
            exp_i_npc   = exp_i_pc + 32'd4;
        end
        if (rsp) begin
            h = mem_q.pop_front();
            if (restart || h.epoch != m_epoch) m_perf++;
            else m_out.push_back(h.addr);
        end
        if (obs_req_valid && imem.req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            due = e + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: obs_req_addr, epoch: m_epoch, due: due});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (restart) begin
            m_out.delete();
            m_epoch++;
            m_fetch_pc = restart_pc & 32'hFFFF_FFFC;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (6) step();
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({i_valid, i_instr, i_pc, i_npc, perf, imem.req_valid} !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: got v=%b instr=%h pc=%h npc=%h perf=%0d req=%b, want all 0",
                     i_valid, i_instr, i_pc, i_npc, perf, imem.req_valid);
        end
        do_reset();
        step();
        n_cmp++;
        if (obs_req_valid !== 1'b1 || obs_req_addr !== BOOT) begin
            n_fail++;
            $display("FAIL reset_first_req: got v=%b addr=%h, want v=1 addr=%h",
                     obs_req_valid, obs_req_addr, BOOT);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_cmp++;
            if ({i_valid, i_pc, i_instr, i_npc} !== {exp_i_valid, exp_i_pc, exp_i_instr, exp_i_npc}) begin
                n_fail++;
                $display("FAIL stream_out k=%0d: got v=%b pc=%h instr=%h npc=%h, want v=%b pc=%h instr=%h npc=%h",
                         k, i_valid, i_pc, i_instr, i_npc, exp_i_valid, exp_i_pc, exp_i_instr, exp_i_npc);
            end
            n_cmp++;
            if (i_valid !== (k >= 3)) begin
                n_fail++;
                $display("FAIL stream_fill k=%0d: got i_valid=%b want %b", k, i_valid, k >= 3);
            end
            if (k == 3) begin
                n_cmp++;
                if (i_pc !== BOOT) begin
                    n_fail++;
                    $display("FAIL stream_first_pc: got %h want %h", i_pc, BOOT);
                end
            end
        end
    endtask

    task automatic test_ready_low();
        logic seen;
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (obs_req_valid !== 1'b1 || obs_req_addr !== BOOT || i_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_low k=%0d: got req=%b addr=%h i_valid=%b, want req=1 addr=%h i_valid=0",
                         k, obs_req_valid, obs_req_addr, i_valid, BOOT);
            end
        end
        ready_pct = 100;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = i_valid;
        end
        n_cmp++;
        if (!seen || i_pc !== BOOT) begin
            n_fail++;
            $display("FAIL ready_low_first: got seen=%b pc=%h, want seen=1 pc=%h", seen, i_pc, BOOT);
        end
    endtask

    task automatic test_restart_drop();
        logic [31:0] perf0;
        do_reset();
        lat_min = 3; lat_max = 3; ready_pct = 100;
        repeat (3) step();
        perf0 = perf;
        restart = 1'b1;
        restart_pc = 32'h8000_1003;
        step();
        restart = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                n_cmp++;
                if (obs_req_valid !== 1'b1 || obs_req_addr !== 32'h8000_1000) begin
                    n_fail++;
                    $display("FAIL restart_req_addr: got v=%b addr=%h, want v=1 addr=80001000",
                             obs_req_valid, obs_req_addr);
                end
            end
            n_cmp++;
            if (i_valid !== (k == 5) || (k == 5 && i_pc !== 32'h8000_1000)) begin
                n_fail++;
                $display("FAIL restart_latency t+%0d: got v=%b pc=%h, want v=%b pc=80001000",
                         k, i_valid, i_pc, k == 5);
            end
        end
        n_cmp++;
        if (perf - perf0 !== 32'd3) begin
            n_fail++;
            $display("FAIL restart_discards: got %0d want 3", perf - perf0);
        end
    endtask

    task automatic test_restart_same_cycle();
        logic [31:0] perf0;
        logic        seen;
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        repeat (6) step();
        perf0 = perf;
        restart = 1'b1;
        restart_pc = 32'h0000_0100;
        step();
        restart = 1'b0;
        n_cmp++;
        if (i_valid !== 1'b0 || perf !== perf0 + 32'd1) begin
            n_fail++;
            $display("FAIL same_cycle_drop: got v=%b perf_delta=%0d, want v=0 perf_delta=1",
                     i_valid, perf - perf0);
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            seen = i_valid;
        end
        n_cmp++;
        if (!seen || i_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL same_cycle_next: got seen=%b pc=%h, want seen=1 pc=00000100", seen, i_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] pcs[$];
        logic [31:0] npcs[$];
        logic [31:0] want_pc[3];
        logic [31:0] want_npc[3];
        want_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        want_npc = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        restart = 1'b1;
        restart_pc = 32'hFFFF_FFF8;
        step();
        restart = 1'b0;
        for (int k = 0; k < 20 && pcs.size() < 3; k++) begin
            step();
            if (i_valid) begin
                pcs.push_back(i_pc);
                npcs.push_back(i_npc);
            end
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (k >= pcs.size() || pcs[k] !== want_pc[k] || npcs[k] !== want_npc[k]) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got n=%0d pc=%h npc=%h, want pc=%h npc=%h", k, pcs.size(),
                         (k < pcs.size()) ? pcs[k] : 32'hx, (k < npcs.size()) ? npcs[k] : 32'hx,
                         want_pc[k], want_npc[k]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_min = 1; lat_max = 6; ready_pct = 70;
        for (int k = 0; k < 10040; k++) begin
            if (k < 10000) begin
                restart = ($urandom_range(99) < 2);
                restart_pc = $urandom;
            end else begin
                restart = 1'b0;
                ready_pct = 100;
            end
            step();
            n_cmp++;
            if ({i_valid, i_pc, i_instr, i_npc} !== {exp_i_valid, exp_i_pc, exp_i_instr, exp_i_npc}) begin
                n_fail++;
                $display("FAIL random_out e=%0d: got v=%b pc=%h instr=%h npc=%h, want v=%b pc=%h instr=%h npc=%h",
                         e, i_valid, i_pc, i_instr, i_npc, exp_i_valid, exp_i_pc, exp_i_instr, exp_i_npc);
            end
            n_cmp++;
            if (obs_req_valid !== exp_req_valid || (exp_req_valid && obs_req_addr !== exp_req_addr)) begin
                n_fail++;
                $display("FAIL random_req e=%0d: got v=%b addr=%h, want v=%b addr=%h",
                         e, obs_req_valid, obs_req_addr, exp_req_valid, exp_req_addr);
            end
            n_cmp++;
            if (perf !== m_perf) begin
                n_fail++;
                $display("FAIL random_perf e=%0d: got %0d want %0d", e, perf, m_perf);
            end
            n_cmp++;
            if (mem_q.size() > DEPTH) begin
                n_fail++;
                $display("FAIL random_credit e=%0d: got %0d outstanding, want <= %0d", e, mem_q.size(), DEPTH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_ready_low();
        test_restart_drop();
        test_restart_same_cycle();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
